// File: rtl/dp_logic_arbiter_pkg.sv
// Shared opcode and FSM state definitions for the shared-logic-unit arbiter.
package dp_logic_arbiter_pkg;

    localparam logic [1:0] OP_OR   = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        EXEC   = 2'd2,
        RESULT = 2'd3
    } state_t;

endpackage

// File: rtl/dp_logic_arbiter_unit.sv
// Combinational N-bit bitwise logic cell shared by all arbiter clients.
module dp_logic_unit
    import dp_logic_arbiter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [1:0]   OP,
    input  logic [N-1:0] IN0,
    input  logic [N-1:0] IN1,
    output logic [N-1:0] Y
);

    // NOTE: give every combinational output a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        Y = IN0;
        case (OP)
            OP_OR:   Y = IN0 | IN1;
            OP_AND:  Y = IN0 & IN1;
            OP_XOR:  Y = IN0 ^ IN1;
            default: Y = IN0;
        endcase
    end

endmodule

// File: rtl/dp_logic_arbiter.sv
// Round-robin arbiter that shares one bitwise logic unit among R requesters
// and returns a registered result through a VALID/RACK handshake.
module dp_logic_arbiter
    import dp_logic_arbiter_pkg::*;
#(
    parameter int N   = 8,
    parameter int R   = 4,
    parameter int IDW = 2
) (
    input  logic           CLK,
    input  logic           nRESET,
    input  logic [R-1:0]   REQ,
    input  logic [2*R-1:0] OP,
    input  logic [N*R-1:0] A,
    input  logic [N*R-1:0] B,
    output logic [R-1:0]   GNT,
    output logic           BUSY,
    output logic [N-1:0]   Y,
    output logic           VALID,
    output logic [IDW-1:0] RID,
    input  logic           RACK
);

    state_t         state, state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic [1:0]     op_q;
    logic [N-1:0]   a_q, b_q;

    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic [R-1:0]   pick_onehot;
    logic [1:0]     sel_op;
    logic [N-1:0]   sel_a, sel_b;
    logic [N-1:0]   lu_y;

    // Scan from the pointer upward with wrap; returns {found, index}.
    // Only indices below R are ever visited, so unused IDs are never granted.
    function automatic logic [IDW:0] rr_pick(input logic [R-1:0] req,
                                             input logic [IDW-1:0] start);
        logic           found;
        logic [IDW-1:0] idx;
        logic [IDW-1:0] k;
        found = 1'b0;
        idx   = '0;
        k     = start;
        for (int i = 0; i < R; i++) begin
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = k;
            end
            k = (k == IDW'(R - 1)) ? '0 : k + 1'b1;
        end
        return {found, idx};
    endfunction

    always_comb begin
        {pick_found, pick_idx} = rr_pick(REQ, ptr);
        pick_onehot = '0;
        for (int i = 0; i < R; i++) begin
            if (pick_found && pick_idx == IDW'(i)) pick_onehot[i] = 1'b1;
        end
    end

    // Operand mux for the registered winner, sampled at the end of GRANT.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < R; i++) begin
            if (win == IDW'(i)) begin
                sel_op = OP[2*i +: 2];
                sel_a  = A[N*i +: N];
                sel_b  = B[N*i +: N];
            end
        end
    end

    dp_logic_unit #(.N(N)) u_logic (
        .OP  (op_q),
        .IN0 (a_q),
        .IN1 (b_q),
        .Y   (lu_y)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_found) state_next = GRANT;
            GRANT:   state_next = EXEC;
            EXEC:    state_next = RESULT;
            RESULT:  if (RACK) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the operand latches are plain flops, not a RAM, so resetting them
    // costs nothing and keeps post-reset behaviour fully deterministic.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            GNT   <= '0;
            ptr   <= '0;
            win   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            Y     <= '0;
            RID   <= '0;
            VALID <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        GNT <= pick_onehot;
                        win <= pick_idx;
                    end
                end
                GRANT: begin
                    op_q <= sel_op;
                    a_q  <= sel_a;
                    b_q  <= sel_b;
                    GNT  <= '0;
                    ptr  <= (win == IDW'(R - 1)) ? '0 : win + 1'b1;
                end
                EXEC: begin
                    Y     <= lu_y;
                    RID   <= win;
                    VALID <= 1'b1;
                end
                RESULT: begin
                    if (RACK) VALID <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_dp_logic_arbiter.sv
// Directed self-checking bench for dp_logic_arbiter (N=8, R=4).
module tb_dp_logic_arbiter;

    localparam int N = 8;
    localparam int R = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [R-1:0]   req;
    logic [2*R-1:0] op;
    logic [N*R-1:0] a, b;
    logic [R-1:0]   gnt;
    logic           busy;
    logic [N-1:0]   y;
    logic           valid;
    logic [IDW-1:0] rid;
    logic           rack;

    int checks = 0;
    int errors = 0;

    dp_logic_arbiter #(.N(N), .R(R), .IDW(IDW)) dut (
        .CLK    (clk),
        .nRESET (rst_n),
        .REQ    (req),
        .OP     (op),
        .A      (a),
        .B      (b),
        .GNT    (gnt),
        .BUSY   (busy),
        .Y      (y),
        .VALID  (valid),
        .RID    (rid),
        .RACK   (rack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_client(input int i, input logic [1:0] o,
                              input logic [N-1:0] va, input logic [N-1:0] vb);
        op[2*i +: 2] = o;
        a[N*i +: N]  = va;
        b[N*i +: N]  = vb;
    endtask

    task automatic expect_out(input string tag, input logic [R-1:0] e_gnt,
                              input logic e_busy, input logic e_valid);
        checks++;
        if (gnt !== e_gnt || busy !== e_busy || valid !== e_valid) begin
            errors++;
            $display("FAIL %s: gnt=%b busy=%b valid=%b, expected gnt=%b busy=%b valid=%b",
                     tag, gnt, busy, valid, e_gnt, e_busy, e_valid);
        end
    endtask

    task automatic expect_result(input string tag, input logic [N-1:0] e_y,
                                 input logic [IDW-1:0] e_rid);
        checks++;
        if (valid !== 1'b1 || y !== e_y || rid !== e_rid) begin
            errors++;
            $display("FAIL %s: valid=%b y=%h rid=%0d, expected valid=1 y=%h rid=%0d",
                     tag, valid, y, rid, e_y, e_rid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0; op = '0; a = '0; b = '0; rack = 1'b0;
        #3;
        checks++;
        if (gnt !== 4'b0 || busy !== 1'b0 || y !== 8'h00 || valid !== 1'b0 || rid !== 2'd0) begin
            errors++;
            $display("FAIL reset: gnt=%b busy=%b y=%h valid=%b rid=%0d, expected all zero",
                     gnt, busy, y, valid, rid);
        end
        #9 rst_n = 1'b1;
        step();
        expect_out("reset_idle", 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        set_client(0, 2'b00, 8'h0F, 8'hF0);
        req = 4'b0001;
        step();                                   // cycle 1
        expect_out("single_c1_grant", 4'b0001, 1'b1, 1'b0);
        req = 4'b0000;
        step();                                   // cycle 2
        expect_out("single_c2_exec", 4'b0000, 1'b1, 1'b0);
        step();                                   // cycle 3
        expect_result("single_c3_result", 8'hFF, 2'd0);
        rack = 1'b1;
        step();                                   // cycle 4
        expect_out("single_c4_idle", 4'b0000, 1'b0, 1'b0);
        rack = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_y [R];
        logic [R-1:0] exp_gnt;
        int k, phase;
        exp_y[0] = 8'h0A; exp_y[1] = 8'hA5; exp_y[2] = 8'hAA; exp_y[3] = 8'hAF;
        set_client(0, 2'b01, 8'hAA, 8'h0F);
        set_client(1, 2'b10, 8'hAA, 8'h0F);
        set_client(2, 2'b11, 8'hAA, 8'h0F);
        set_client(3, 2'b00, 8'hAA, 8'h0F);
        do_reset();
        req  = 4'b1111;
        rack = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            k       = ((c - 1) / 4) % 4;
            phase   = (c - 1) % 4;
            exp_gnt = (phase == 0) ? 4'(1 << k) : 4'b0000;
            expect_out($sformatf("rr_c%0d", c), exp_gnt, phase != 3, phase == 2);
            if (phase == 2) expect_result($sformatf("rr_result_c%0d", c), exp_y[k], IDW'(k));
        end
        req  = 4'b0000;
        rack = 1'b0;
    endtask

    task automatic test_backpressure();
        set_client(2, 2'b11, 8'h3C, 8'h00);
        req = 4'b0010;                            // pointer is 1 after round robin
        step();
        expect_out("bp_c1_grant", 4'b0010, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        step();                                   // cycle 3, RESULT
        req = 4'b0100;
        for (int c = 3; c <= 7; c++) begin
            expect_result($sformatf("bp_hold_c%0d", c), 8'hA5, 2'd1);
            expect_out($sformatf("bp_flags_c%0d", c), 4'b0000, 1'b1, 1'b1);
            if (c < 7) step();
        end
        rack = 1'b1;
        step();                                   // cycle 8, IDLE
        expect_out("bp_c8_idle", 4'b0000, 1'b0, 1'b0);
        rack = 1'b0;
        step();                                   // cycle 9
        expect_out("bp_c9_grant2", 4'b0100, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        step();
        expect_result("bp_c11_result2", 8'h3C, 2'd2);
        rack = 1'b1;
        step();
        expect_out("bp_c12_idle", 4'b0000, 1'b0, 1'b0);
        rack = 1'b0;
    endtask

    task automatic test_req_withdrawn();
        set_client(1, 2'b10, 8'h55, 8'h0F);
        req = 4'b0010;
        step();
        expect_out("wd_c1_grant", 4'b0010, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        step();
        expect_result("wd_c3_result", 8'h5A, 2'd1);
        rack = 1'b1;
        step();
        rack = 1'b0;
        expect_out("wd_c4_idle", 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        set_client(0, 2'b01, 8'hAA, 8'h0F);
        set_client(3, 2'b00, 8'h11, 8'h22);
        req = 4'b0001;
        step();
        expect_out("ar_c1_grant", 4'b0001, 1'b1, 1'b0);
        req = 4'b0000;
        step();                                   // cycle 2, EXEC
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0 || y !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: valid=%b gnt=%b busy=%b y=%h, expected all zero",
                     valid, gnt, busy, y);
        end
        step();
        expect_out("ar_held", 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        req = 4'b1001;
        step();
        expect_out("ar_ptr_reset_grant", 4'b0001, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        step();
        expect_result("ar_result", 8'h0A, 2'd0);
        rack = 1'b1;
        step();
        rack = 1'b0;
    endtask

    task automatic test_stray_rack();
        set_client(2, 2'b11, 8'hC3, 8'hFF);
        rack = 1'b1;
        req  = 4'b0100;                           // pointer is 1 here
        step();
        expect_out("sr_c1_grant", 4'b0100, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        expect_out("sr_c2_exec", 4'b0000, 1'b1, 1'b0);
        step();
        rack = 1'b0;
        expect_result("sr_c3_result", 8'hC3, 2'd2);
        step();
        step();
        expect_result("sr_c5_wait", 8'hC3, 2'd2);
        rack = 1'b1;
        step();
        expect_out("sr_c6_idle", 4'b0000, 1'b0, 1'b0);
        rack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_req_withdrawn();
        test_async_reset();
        test_stray_rack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
